// File: rtl/iq_integrator_par.sv
`default_nettype none
// ============================================================================
//  Module   : iq_integrator_par
//  Purpose  : Sums LANES rotated I/Q samples per clock over a programmable
//             number of valid beats into signed saturating accumulators and
//             holds the result behind a valid/ready handshake.
//  Ports    :
//    clk100        in   system clock, rising edge
//    reset_n       in   synchronous active-low reset
//    start         in   frame start (first beat may be on the same cycle)
//    sample_length in   beats per frame, captured on an accepted start
//    in_valid      in   lane data valid this cycle
//    data_i_rot    in   packed signed I lanes, lane 0 in LSBs
//    data_q_rot    in   packed signed Q lanes, lane 0 in LSBs
//    out_ready     in   downstream accepts the held result
//    busy          out  integrating
//    iq_valid      out  result valid, held until accepted
//    i_val/q_val   out  signed integrated I/Q
//    saturated     out  a clamp occurred during this frame
//    start_dropped out  one-cycle pulse, start arrived while not idle
//  Revision : 1.0  initial release
// ============================================================================
module iq_integrator_par #(
  parameter int LANES  = 5,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int LEN_W  = 11
) (
  input  logic                    clk100,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [LEN_W-1:0]        sample_length,
  input  logic                    in_valid,
  input  logic [LANES*DATA_W-1:0] data_i_rot,
  input  logic [LANES*DATA_W-1:0] data_q_rot,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    iq_valid,
  output logic [ACC_W-1:0]        i_val,
  output logic [ACC_W-1:0]        q_val,
  output logic                    saturated,
  output logic                    start_dropped
);

  // Up to 8 lanes summed: 3 extra bits make the lane sum overflow-free.
  localparam int SUM_W = DATA_W + 3;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_INTEGRATE = 2'd1,
    S_HOLD      = 2'd2
  } state_t;

  state_t state, state_n;

  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;

  // --------------------------------------------------------------------------
  // Lane unpacking; unused tree inputs are padded with zero.
  // --------------------------------------------------------------------------
  logic signed [SUM_W-1:0] lane_i [8];
  logic signed [SUM_W-1:0] lane_q [8];

  generate
    for (genvar k = 0; k < 8; k++) begin : g_lane
      if (k < LANES) begin : g_used
        assign lane_i[k] = SUM_W'($signed(data_i_rot[k*DATA_W +: DATA_W]));
        assign lane_q[k] = SUM_W'($signed(data_q_rot[k*DATA_W +: DATA_W]));
      end else begin : g_pad
        assign lane_i[k] = '0;
        assign lane_q[k] = '0;
      end
    end
  endgenerate

  // Balanced three-level adder tree.
  logic signed [SUM_W-1:0] sum_i, sum_q;
  always_comb begin
    sum_i = ((lane_i[0] + lane_i[1]) + (lane_i[2] + lane_i[3])) +
            ((lane_i[4] + lane_i[5]) + (lane_i[6] + lane_i[7]));
    sum_q = ((lane_q[0] + lane_q[1]) + (lane_q[2] + lane_q[3])) +
            ((lane_q[4] + lane_q[5]) + (lane_q[6] + lane_q[7]));
  end

  // Returns {clipped, result}. The add is done one bit wider; a disagreement
  // between the two top bits means the true sum left the ACC_W range.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                             input logic [SUM_W-1:0] s);
    logic signed [ACC_W:0] wide;
    wide = $signed({acc[ACC_W-1], acc}) + (ACC_W+1)'($signed(s));
    if (wide[ACC_W] != wide[ACC_W-1])
      sat_add = {1'b1, wide[ACC_W], {(ACC_W-1){~wide[ACC_W]}}};
    else
      sat_add = {1'b0, wide[ACC_W-1:0]};
  endfunction

  // --------------------------------------------------------------------------
  // Next-state and datapath control
  // --------------------------------------------------------------------------
  logic             clear;       // start accepted: reload length, zero sums
  logic             accumulate;  // add this beat
  logic [ACC_W-1:0] acc_base_i, acc_base_q;
  logic             sat_base;
  logic [LEN_W-1:0] cnt_base, cnt_inc, len_eff;
  logic [ACC_W:0]   add_i, add_q;

  always_comb begin
    state_n    = state;
    clear      = 1'b0;
    accumulate = 1'b0;

    // On the start cycle the beat is added onto a freshly cleared frame.
    acc_base_i = i_val;
    acc_base_q = q_val;
    sat_base   = saturated;
    cnt_base   = cnt;
    len_eff    = len_q;
    if (state == S_IDLE) begin
      acc_base_i = '0;
      acc_base_q = '0;
      sat_base   = 1'b0;
      cnt_base   = '0;
      len_eff    = sample_length;
    end
    cnt_inc = cnt_base + LEN_W'(1);
    add_i   = sat_add(acc_base_i, sum_i);
    add_q   = sat_add(acc_base_q, sum_q);

    case (state)
      S_IDLE: begin
        if (start) begin
          clear = 1'b1;
          if (sample_length == '0) begin
            state_n = S_HOLD;
          end else begin
            accumulate = in_valid;
            state_n    = (in_valid && (cnt_inc == len_eff)) ? S_HOLD : S_INTEGRATE;
          end
        end
      end
      S_INTEGRATE: begin
        // A stray start suppresses the beat that arrives with it.
        if (in_valid && !start) begin
          accumulate = 1'b1;
          if (cnt_inc == len_eff)
            state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready)
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clk100) begin
    if (!reset_n) begin
      cnt           <= '0;
      len_q         <= '0;
      i_val         <= '0;
      q_val         <= '0;
      saturated     <= 1'b0;
      start_dropped <= 1'b0;
    end else begin
      start_dropped <= start && (state != S_IDLE);
      if (clear)
        len_q <= sample_length;
      if (accumulate) begin
        i_val     <= add_i[ACC_W-1:0];
        q_val     <= add_q[ACC_W-1:0];
        saturated <= sat_base | add_i[ACC_W] | add_q[ACC_W];
        cnt       <= cnt_inc;
      end else if (clear) begin
        i_val     <= '0;
        q_val     <= '0;
        saturated <= 1'b0;
        cnt       <= '0;
      end
    end
  end

  assign busy     = (state == S_INTEGRATE);
  assign iq_valid = (state == S_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_iq_integrator_par.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_iq_integrator_par
//  Purpose  : Self-checking bench for iq_integrator_par. Two instances share
//             stimulus: one at default widths, one with a 20-bit accumulator
//             so that clamping is reachable.
//  Revision : 1.0  initial release
// ============================================================================
module tb_iq_integrator_par;

  localparam int LANES  = 5;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 11;
  localparam int ACC_A  = 32;
  localparam int ACC_B  = 20;

  logic clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  logic                    reset_n, start, in_valid, out_ready;
  logic [LEN_W-1:0]        sample_length;
  logic [LANES*DATA_W-1:0] data_i_rot, data_q_rot;

  logic             busy_a, iq_valid_a, sat_a, drop_a;
  logic [ACC_A-1:0] i_a, q_a;
  logic             busy_b, iq_valid_b, sat_b, drop_b;
  logic [ACC_B-1:0] i_b, q_b;

  iq_integrator_par #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_A), .LEN_W(LEN_W)) dut_a (
    .clk100(clk100), .reset_n(reset_n), .start(start), .sample_length(sample_length),
    .in_valid(in_valid), .data_i_rot(data_i_rot), .data_q_rot(data_q_rot),
    .out_ready(out_ready), .busy(busy_a), .iq_valid(iq_valid_a), .i_val(i_a),
    .q_val(q_a), .saturated(sat_a), .start_dropped(drop_a));

  iq_integrator_par #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_B), .LEN_W(LEN_W)) dut_b (
    .clk100(clk100), .reset_n(reset_n), .start(start), .sample_length(sample_length),
    .in_valid(in_valid), .data_i_rot(data_i_rot), .data_q_rot(data_q_rot),
    .out_ready(out_ready), .busy(busy_b), .iq_valid(iq_valid_b), .i_val(i_b),
    .q_val(q_b), .saturated(sat_b), .start_dropped(drop_b));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: frame-level behaviour with plain integer arithmetic.
  // mode: 0 waiting for a start, 1 collecting beats, 2 result on offer.
  // --------------------------------------------------------------------------
  typedef struct {
    int     mode;
    longint si, sq;
    int     cnt, len;
    bit     sat, drop;
  } mdl_t;

  mdl_t ma, mb;
  int   li [LANES];
  int   lq [LANES];

  function automatic longint clip(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input int w, input bit rn,
                                    input bit st, input bit v, input bit rdy,
                                    input int L, input longint di, input longint dq);
    mdl_t   n;
    longint ti, tq;
    n = m;
    if (!rn) begin
      n = '{default: 0};
      return n;
    end
    n.drop = st && (m.mode != 0);
    case (m.mode)
      0: if (st) begin
        n.si = 0; n.sq = 0; n.sat = 0; n.cnt = 0; n.len = L;
        if (L == 0) n.mode = 2;
        else begin
          if (v) begin
            ti = clip(di, w); tq = clip(dq, w);
            n.sat = (ti != di) || (tq != dq);
            n.si = ti; n.sq = tq; n.cnt = 1;
          end
          n.mode = (n.cnt == L) ? 2 : 1;
        end
      end
      1: if (v && !st) begin
        ti = clip(m.si + di, w); tq = clip(m.sq + dq, w);
        n.sat = m.sat || (ti != m.si + di) || (tq != m.sq + dq);
        n.si = ti; n.sq = tq;
        n.cnt = m.cnt + 1;
        if (n.cnt == n.len) n.mode = 2;
      end
      2: if (rdy) n.mode = 0;
      default: n.mode = 0;
    endcase
    return n;
  endfunction

  task automatic check_model();
    cmp("a.busy",      busy_a,          ma.mode == 1);
    cmp("a.iq_valid",  iq_valid_a,      ma.mode == 2);
    cmp("a.i_val",     $signed(i_a),    ma.si);
    cmp("a.q_val",     $signed(q_a),    ma.sq);
    cmp("a.saturated", sat_a,           ma.sat);
    cmp("a.start_dropped", drop_a,      ma.drop);
    cmp("b.busy",      busy_b,          mb.mode == 1);
    cmp("b.iq_valid",  iq_valid_b,      mb.mode == 2);
    cmp("b.i_val",     $signed(i_b),    mb.si);
    cmp("b.q_val",     $signed(q_b),    mb.sq);
    cmp("b.saturated", sat_b,           mb.sat);
    cmp("b.start_dropped", drop_b,      mb.drop);
  endtask

  // Apply the current inputs for one clock, advance the model, check after the edge.
  task automatic tick();
    longint di, dq;
    di = 0; dq = 0;
    for (int k = 0; k < LANES; k++) begin
      data_i_rot[k*DATA_W +: DATA_W] = li[k][DATA_W-1:0];
      data_q_rot[k*DATA_W +: DATA_W] = lq[k][DATA_W-1:0];
      di += li[k];
      dq += lq[k];
    end
    ma = mdl_step(ma, ACC_A, reset_n, start, in_valid, out_ready, int'(sample_length), di, dq);
    mb = mdl_step(mb, ACC_B, reset_n, start, in_valid, out_ready, int'(sample_length), di, dq);
    @(posedge clk100);
    #1;
    check_model();
  endtask

  task automatic set_all(input int iv, input int qv);
    for (int k = 0; k < LANES; k++) begin
      li[k] = iv;
      lq[k] = qv;
    end
  endtask

  // Ticks until iq_valid on the default instance; returns cycles consumed.
  task automatic wait_valid(input int start_cyc, output int cyc);
    cyc = start_cyc;
    while (!iq_valid_a && cyc < 300) begin
      tick();
      cyc++;
    end
  endtask

  typedef struct {
    int     iv, qv, len;
    longint ea_i, ea_q, eb_i, eb_q;
    bit     eb_sat;
    int     lat;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int drops;

    tbl[0] = '{iv: 100,    qv: -50,   len: 4,   ea_i: 2000,     ea_q: -1000,  eb_i: 2000,    eb_q: -1000,   eb_sat: 0, lat: 4};
    tbl[1] = '{iv: 32767,  qv: 0,     len: 8,   ea_i: 1310680,  ea_q: 0,      eb_i: 524287,  eb_q: 0,       eb_sat: 1, lat: 8};
    tbl[2] = '{iv: -32768, qv: 1,     len: 8,   ea_i: -1310720, ea_q: 40,     eb_i: -524288, eb_q: 40,      eb_sat: 1, lat: 8};
    tbl[3] = '{iv: 7,      qv: 7,     len: 0,   ea_i: 0,        ea_q: 0,      eb_i: 0,       eb_q: 0,       eb_sat: 0, lat: 1};
    tbl[4] = '{iv: 1,      qv: -1,    len: 1,   ea_i: 5,        ea_q: -5,     eb_i: 5,       eb_q: -5,      eb_sat: 0, lat: 1};
    tbl[5] = '{iv: 1000,   qv: -1000, len: 100, ea_i: 500000,   ea_q: -500000, eb_i: 500000, eb_q: -500000, eb_sat: 0, lat: 100};
    tbl[6] = '{iv: 1000,   qv: -1000, len: 105, ea_i: 525000,   ea_q: -525000, eb_i: 524287, eb_q: -524288, eb_sat: 1, lat: 105};

    ma = '{default: 0};
    mb = '{default: 0};
    reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sample_length = '0;
    set_all(0, 0);
    data_i_rot = '0; data_q_rot = '0;

    // Reset state
    tick();
    tick();
    cmp("reset iq_valid", iq_valid_a, 0);
    cmp("reset i_val", $signed(i_a), 0);
    reset_n = 1'b1;
    tick();

    // Table of single frames, in_valid and out_ready held high
    for (int t = 0; t < 7; t++) begin
      set_all(tbl[t].iv, tbl[t].qv);
      in_valid = 1'b1; out_ready = 1'b1;
      start = 1'b1; sample_length = LEN_W'(tbl[t].len);
      tick();
      start = 1'b0;
      wait_valid(1, cyc);
      cmp($sformatf("vec%0d latency", t), cyc, tbl[t].lat);
      cmp($sformatf("vec%0d a.i", t), $signed(i_a), tbl[t].ea_i);
      cmp($sformatf("vec%0d a.q", t), $signed(q_a), tbl[t].ea_q);
      cmp($sformatf("vec%0d a.sat", t), sat_a, 0);
      cmp($sformatf("vec%0d b.i", t), $signed(i_b), tbl[t].eb_i);
      cmp($sformatf("vec%0d b.q", t), $signed(q_b), tbl[t].eb_q);
      cmp($sformatf("vec%0d b.sat", t), sat_b, tbl[t].eb_sat);
      tick();
      cmp($sformatf("vec%0d single pulse", t), iq_valid_a, 0);
    end

    // Gaps on beats 2 and 3: same sums, two cycles later
    set_all(100, -50);
    in_valid = 1'b1; out_ready = 1'b1;
    start = 1'b1; sample_length = LEN_W'(4);
    tick();
    start = 1'b0; in_valid = 1'b0;
    tick(); tick();
    in_valid = 1'b1;
    wait_valid(3, cyc);
    cmp("gap latency", cyc, 6);
    cmp("gap i", $signed(i_a), 2000);
    cmp("gap q", $signed(q_a), -1000);
    tick();

    // Result held with out_ready low; a start during the hold is dropped
    set_all(10, 20);
    out_ready = 1'b0; in_valid = 1'b1;
    start = 1'b1; sample_length = LEN_W'(3);
    tick();
    start = 1'b0;
    wait_valid(1, cyc);
    cmp("hold latency", cyc, 3);
    drops = 0;
    for (int c = 0; c < 10; c++) begin
      start = (c == 2);
      sample_length = LEN_W'(5);
      tick();
      if (drop_a) drops++;
      cmp("hold iq_valid", iq_valid_a, 1);
      cmp("hold i", $signed(i_a), 150);
      cmp("hold q", $signed(q_a), 300);
    end
    start = 1'b0;
    cmp("hold drop count", drops, 1);
    out_ready = 1'b1;
    tick();
    cmp("accepted", iq_valid_a, 0);
    set_all(-3, 4);
    start = 1'b1; sample_length = LEN_W'(2);
    tick();
    start = 1'b0;
    wait_valid(1, cyc);
    cmp("next frame latency", cyc, 2);
    cmp("next frame i", $signed(i_a), -30);
    cmp("next frame q", $signed(q_a), 40);
    tick();

    // Reset on beat 3 of a 10-beat frame
    set_all(7, -7);
    start = 1'b1; sample_length = LEN_W'(10);
    tick();
    start = 1'b0;
    tick();
    cmp("pre-reset busy", busy_a, 1);
    reset_n = 1'b0;
    tick();
    cmp("reset busy", busy_a, 0);
    cmp("reset valid", iq_valid_a, 0);
    cmp("reset i", $signed(i_a), 0);
    cmp("reset q", $signed(q_a), 0);
    reset_n = 1'b1;
    set_all(1, 2);
    start = 1'b1; sample_length = LEN_W'(2);
    tick();
    start = 1'b0;
    wait_valid(1, cyc);
    cmp("post-reset i", $signed(i_a), 10);
    cmp("post-reset q", $signed(q_a), 20);
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      reset_n       = ($urandom_range(0, 299) != 0);
      start         = ($urandom_range(0, 5) == 0);
      sample_length = LEN_W'($urandom_range(0, 12));
      in_valid      = ($urandom_range(0, 3) != 0);
      out_ready     = ($urandom_range(0, 1) != 0);
      for (int k = 0; k < LANES; k++) begin
        li[k] = int'($urandom_range(0, 65535)) - 32768;
        lq[k] = int'($urandom_range(0, 65535)) - 32768;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
